riscv_mem_arbiter: RTL and testbench

- Shares one single-port synchronous word RAM between the core's instruction-fetch port and its load/store port, so the unicycle core can run from a unified memory.
- Data accesses have priority. A starvation counter forces a fetch grant after STARVE_LIMIT consecutive denials.
- Adds alignment/range checking and a one-cycle response pipeline matching the RAM read latency.
- Sits between the core's fetch/LSU request interfaces and the memory macro.

---
 rtl/riscv_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// ============================================================================
//  Module      : riscv_mem_arbiter
//  Description : Shares one single-port synchronous word RAM between the
//                instruction-fetch and load/store ports of the core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_arbiter #(
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_ready,
    output logic          if_valid,
    output logic [31:0]   if_rdata,
    output logic          if_err,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic [3:0]    dm_wstrb,
    output logic          dm_ready,
    output logic          dm_valid,
    output logic [31:0]   dm_rdata,
    output logic          dm_err,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [1:0] c_OWN_NONE   = 2'd0;
    localparam logic [1:0] c_OWN_IF     = 2'd1;
    localparam logic [1:0] c_OWN_DM     = 2'd2;
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]    r_starve_cnt;
    logic [1:0]    r_resp_owner;
    logic          r_resp_err;
    logic          r_resp_store;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;

    logic w_if_fault;
    logic w_dm_fault;
    logic w_starved;
    logic w_if_win;
    logic w_if_issue;
    logic w_dm_issue;

    // Anything at or above 4*2^AW has a nonzero bit above the word index.
    assign w_if_fault = (if_addr[1:0] != 2'b00) || (|if_addr[31:AW+2]);
    assign w_dm_fault = (dm_addr[1:0] != 2'b00) || (|dm_addr[31:AW+2]) ||
                        (dm_we && (dm_wstrb == 4'b0000));

    assign w_starved = (r_starve_cnt == c_STARVE_MAX);
    assign w_if_win  = if_req && (!dm_req || w_starved);

    always_comb begin
        if_ready   = !rst && w_if_win;
        dm_ready   = !rst && dm_req && !w_if_win;
        w_if_issue = if_ready && !w_if_fault;
        w_dm_issue = dm_ready && !w_dm_fault;
        mem_en     = w_if_issue || w_dm_issue;
        mem_we     = 4'b0000;
        mem_addr   = r_mem_addr;
        mem_wdata  = r_mem_wdata;
        if (w_dm_issue) begin
            mem_addr = dm_addr[AW+1:2];
            if (dm_we) begin
                mem_we    = dm_wstrb;
                mem_wdata = dm_wdata;
            end
        end else if (w_if_issue) begin
            mem_addr = if_addr[AW+1:2];
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
            r_resp_owner <= c_OWN_NONE;
            r_resp_err   <= 1'b0;
            r_resp_store <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
        end else begin
            r_mem_addr  <= mem_addr;
            r_mem_wdata <= mem_wdata;
            if (!if_req || if_ready)
                r_starve_cnt <= 4'd0;
            else if (!w_starved)
                r_starve_cnt <= r_starve_cnt + 4'd1;
            if (if_ready) begin
                r_resp_owner <= c_OWN_IF;
                r_resp_err   <= w_if_fault;
                r_resp_store <= 1'b0;
            end else if (dm_ready) begin
                r_resp_owner <= c_OWN_DM;
                r_resp_err   <= w_dm_fault;
                r_resp_store <= dm_we;
            end else begin
                r_resp_owner <= c_OWN_NONE;
                r_resp_err   <= 1'b0;
                r_resp_store <= 1'b0;
            end
        end
    end

    // RAM data is only forwarded for a clean read; faults and store acks return 0.
    always_comb begin
        if_valid = (r_resp_owner == c_OWN_IF);
        dm_valid = (r_resp_owner == c_OWN_DM);
        if_err   = if_valid && r_resp_err;
        dm_err   = dm_valid && r_resp_err;
        if_rdata = (if_valid && !r_resp_err) ? mem_rdata : 32'd0;
        dm_rdata = (dm_valid && !r_resp_err && !r_resp_store) ? mem_rdata : 32'd0;
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
// ============================================================================
//  Module      : tb_riscv_mem_arbiter
//  Description : Directed self-checking bench for riscv_mem_arbiter with a
//                behavioural single-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_mem_arbiter;

    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_ready, if_valid, if_err;
    logic [31:0]   if_rdata;
    logic          dm_req, dm_we;
    logic [31:0]   dm_addr, dm_wdata;
    logic [3:0]    dm_wstrb;
    logic          dm_ready, dm_valid, dm_err;
    logic [31:0]   dm_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0] ram [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    riscv_mem_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
        .clock(clock), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_ready(dm_ready), .dm_valid(dm_valid),
        .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clock);
        #1;
    endtask

    task automatic idle;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    endtask

    int  exp_if_ready [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int  prev_grant;

    initial begin
        for (int i = 0; i < (1<<AW); i++) ram[i] = 32'd0;
        ram[4] = 32'h00500093;
        mem_rdata = 32'd0;
        rst = 1'b1; idle();
        if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_wstrb = 4'd0;

        step();
        step();
        if_req = 1'b1; dm_req = 1'b1; #1;
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_dm_ready", {31'd0, dm_ready}, 32'd0);
        step();
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("rst_mem_en",   {31'd0, mem_en},   32'd0);
        chk("rst_mem_addr", 32'(mem_addr),     32'd0);
        chk("rst_mem_wdata", mem_wdata,        32'd0);

        // Fetch of word 4
        rst = 1'b0; idle(); if_req = 1'b1; if_addr = 32'h10; #1;
        chk("f_ready",    {31'd0, if_ready}, 32'd1);
        chk("f_mem_en",   {31'd0, mem_en},   32'd1);
        chk("f_mem_addr", 32'(mem_addr),     32'd4);
        chk("f_mem_we",   32'(mem_we),       32'd0);
        step();
        idle(); #1;
        chk("f_valid", {31'd0, if_valid}, 32'd1);
        chk("f_rdata", if_rdata,          32'h00500093);
        chk("f_err",   {31'd0, if_err},   32'd0);
        chk("f_dmv",   {31'd0, dm_valid}, 32'd0);
        chk("idle_en", {31'd0, mem_en},   32'd0);
        chk("idle_addr_hold", 32'(mem_addr), 32'd4);

        // Partial store then load back
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'b0011; #1;
        chk("st_ready",  {31'd0, dm_ready}, 32'd1);
        chk("st_we",     32'(mem_we),       32'h3);
        chk("st_addr",   32'(mem_addr),     32'd8);
        chk("st_wdata",  mem_wdata,         32'hDEADBEEF);
        step();
        dm_we = 1'b0; #1;
        chk("st_ack_v",  {31'd0, dm_valid}, 32'd1);
        chk("st_ack_rd", dm_rdata,          32'd0);
        chk("st_ack_e",  {31'd0, dm_err},   32'd0);
        chk("ld_ready",  {31'd0, dm_ready}, 32'd1);
        chk("ld_we",     32'(mem_we),       32'd0);
        chk("ld_wdata_hold", mem_wdata,     32'hDEADBEEF);
        step();
        idle(); #1;
        chk("ld_valid",  {31'd0, dm_valid}, 32'd1);
        chk("ld_rdata",  dm_rdata,          32'h0000BEEF);
        step();

        // Both ports requesting continuously
        prev_grant = 0;
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; #1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("arb%0d_if_ready", c), {31'd0, if_ready}, 32'(exp_if_ready[c]));
            chk($sformatf("arb%0d_dm_ready", c), {31'd0, dm_ready}, 32'(1 - exp_if_ready[c]));
            chk($sformatf("arb%0d_if_valid", c), {31'd0, if_valid}, 32'(prev_grant == 1));
            chk($sformatf("arb%0d_dm_valid", c), {31'd0, dm_valid}, 32'(prev_grant == 2));
            prev_grant = (exp_if_ready[c] != 0) ? 1 : 2;
            step();
        end
        idle(); #1;
        chk("arb_last_if_valid", {31'd0, if_valid}, 32'd1);
        chk("arb_last_if_rdata", if_rdata,          32'h00500093);
        step();

        // Faults: misaligned load, out-of-range fetch, last legal word
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h22; #1;
        chk("mis_ready",  {31'd0, dm_ready}, 32'd1);
        chk("mis_mem_en", {31'd0, mem_en},   32'd0);
        step();
        idle(); if_req = 1'b1; if_addr = 32'h1000; #1;
        chk("mis_valid", {31'd0, dm_valid}, 32'd1);
        chk("mis_err",   {31'd0, dm_err},   32'd1);
        chk("mis_rdata", dm_rdata,          32'd0);
        chk("oob_ready",  {31'd0, if_ready}, 32'd1);
        chk("oob_mem_en", {31'd0, mem_en},   32'd0);
        step();
        if_addr = 32'hFFC; #1;
        chk("oob_valid", {31'd0, if_valid}, 32'd1);
        chk("oob_err",   {31'd0, if_err},   32'd1);
        chk("oob_rdata", if_rdata,          32'd0);
        chk("last_mem_en",   {31'd0, mem_en}, 32'd1);
        chk("last_mem_addr", 32'(mem_addr),   32'h3FF);
        step();
        idle(); #1;
        chk("last_valid", {31'd0, if_valid}, 32'd1);
        chk("last_err",   {31'd0, if_err},   32'd0);

        // Store with empty byte mask
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678; dm_wstrb = 4'b0000; #1;
        chk("wz_ready",  {31'd0, dm_ready}, 32'd1);
        chk("wz_mem_en", {31'd0, mem_en},   32'd0);
        chk("wz_mem_we", 32'(mem_we),       32'd0);
        step();
        idle(); #1;
        chk("wz_valid", {31'd0, dm_valid}, 32'd1);
        chk("wz_err",   {31'd0, dm_err},   32'd1);
        chk("wz_mem_we2", 32'(mem_we),     32'd0);
        chk("wz_ram", ram[16], 32'd0);

        // Reset right after a fetch grant
        if_req = 1'b1; if_addr = 32'h10; #1;
        chk("rg_ready", {31'd0, if_ready}, 32'd1);
        step();
        rst = 1'b1; dm_req = 1'b1; #1;
        chk("rr_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rr_dm_ready", {31'd0, dm_ready}, 32'd0);
        step();
        idle(); #1;
        chk("rr_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rr_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("rr_if_err",   {31'd0, if_err},   32'd0);
        chk("rr_if_rdata", if_rdata,          32'd0);
        chk("rr_mem_en",   {31'd0, mem_en},   32'd0);
        chk("rr_mem_addr", 32'(mem_addr),     32'd0);
        chk("rr_mem_wdata", mem_wdata,        32'd0);
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h20; #1;
        chk("rr_starve_clear", {31'd0, dm_ready}, 32'd1);
        step();
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
